mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares the single-port synchronous data/instruction RAM between the core's instruction-fetch port and its load/store port. It sits between the PUCRS-RV core and `RAM_mem`, and replaces the bare address mux with a request/grant handshake. It also routes the one-cycle-late read data to the right requester and serves the memory-mapped cycle timer. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- `DATA_BURST_MAX`, default 4: maximum consecutive data grants while fetch is waiting; must be 1..15.
- `TIMER_ADDR`, default 32'h80006000: word address of the read-only cycle timer.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request.
- `i_address`  in  32  fetch address.
- `i_gnt`  out  1  fetch granted this cycle (combinational).
- `i_rvalid`  out  1  fetch data valid (cycle after grant).
- `i_rdata`  out  32  fetch data.
- `d_req`  in  1  load/store request.
- `d_we`  in  4  byte write enables; 4'b0000 means read.
- `d_address`  in  32  load/store address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  load/store granted this cycle (combinational).
- `d_rvalid`  out  1  load data valid (cycle after a read grant).
- `d_rdata`  out  32  load data.
- `mem_en`  out  1  RAM access this cycle.
- `mem_we`  out  4  RAM byte write enables.
- `mem_address`  out  32  RAM address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data; valid one cycle after `mem_en`.

## Operation
- **Grant rule, evaluated combinationally each cycle:**
  - Only one requester: it is granted.
  - Both requesting: data wins, unless `starve_cnt == DATA_BURST_MAX`, in which case fetch wins.
  - Neither requesting: no grant.
- **Starvation counter `starve_cnt`** (4 bits):
  - Increments, saturating at `DATA_BURST_MAX`, when `d_gnt` and `i_req` are both high.
  - Clears when `i_gnt` is high or `i_req` is low.
- **Memory drive:**
  - The granted requester's address, data and write enables drive `mem_*` in the same cycle.
  - `mem_en` = 1 on every grant except data accesses to `TIMER_ADDR`.
  - With no grant: `mem_en` = 0, `mem_we` = 0, `mem_address` = 0, `mem_wdata` = 0.
- **Timer:**
  - 32-bit `cycle_cnt` increments every cycle out of reset and wraps from 32'hFFFFFFFF to 0.
  - A data read of `TIMER_ADDR` captures `cycle_cnt` at the grant edge into `timer_q` and returns it.
  - A data write to `TIMER_ADDR` is granted and dropped: `mem_en` = 0, counter unaffected.
- **Response owner register `owner`:**
  - Encodings: NONE, INSTR, DMEM, DTIMER.
  - Loaded each edge from the current grant: INSTR on `i_gnt`; DMEM on a data read to RAM; DTIMER on a data read of `TIMER_ADDR`; otherwise NONE. Writes load NONE.
- **Read responses:**
  - `i_rvalid` = (owner == INSTR). `i_rdata` = `mem_rdata` when `i_rvalid`, else 0.
  - `d_rvalid` = (owner == DMEM or DTIMER). `d_rdata` = `mem_rdata` for DMEM, `timer_q` for DTIMER, else 0.
  - Writes produce no `d_rvalid`; a write is complete at its grant edge.
- **Reset:**
  - `reset` low clears `owner` to NONE, `starve_cnt` to 0, `cycle_cnt` to 0 and `timer_q` to 0, immediately and asynchronously.
  - Reset values of outputs: `i_rvalid` = `d_rvalid` = 0 and `i_rdata` = `d_rdata` = 0. Grant and `mem_*` outputs follow the combinational rules.
  - An in-flight response is discarded.

## Timing
- Request to grant: 0 cycles, combinational; requesters sample `*_gnt` at the rising edge.
- Grant to read data: exactly 1 cycle.
- Throughput: one access per cycle in total, back-to-back allowed, no bubbles.
- A requester holds its request until granted; the arbiter assumes `d_address`, `d_we` and `d_wdata` stable while `d_req` is high.
- Worst-case fetch wait under continuous data traffic: `DATA_BURST_MAX` cycles, then one fetch grant.
- The timer value returned equals the count at the grant edge. It is not the value at the response cycle.

## Test plan
- **Reset.** Hold `reset` = 0 with both requests high for 3 cycles. Expect `i_rvalid` = `d_rvalid` = 0 and `*_rdata` = 0. After release, `cycle_cnt` reads 0 at the first edge.
- **Solo fetch.** `i_req` = 1 with `i_address` = 0x100 for 3 cycles; the RAM holds 0xA, 0xB, 0xC at 0x100..0x108 while the address increments. Expect `i_gnt` = 1 each cycle, `i_rvalid` on cycles 1..3, and `i_rdata` 0xA, 0xB, 0xC.
- **Starvation bound.** `d_req` = 1 continuously with reads, and `i_req` = 1, with `DATA_BURST_MAX` = 4. Expect grant pattern D,D,D,D,I repeating. `i_rvalid` pulses once every 5 cycles.
- **Store then load.** `d_we` = 4'b0011 with `d_wdata` = 0xDEADBEEF to 0x200, over a word previously 0x0. Next cycle, read 0x200. Expect `d_rvalid` on the read's response cycle only, with `d_rdata` = 0x0000BEEF.
- **Timer read.** Read `TIMER_ADDR` at cycle 10 after reset. Expect `mem_en` = 0 in that cycle and `d_rdata` = 10 the following cycle. A write to `TIMER_ADDR` changes nothing and produces no `d_rvalid`.
- **Reset mid-response.** Grant a data read, then assert `reset` before the next edge. Expect `d_rvalid` to drop immediately, and no stale response after reset releases.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store, with data
// priority bounded by a starvation counter, 1-cycle read response routing and a cycle timer.
module mem_port_arbiter #(
  parameter int          DATA_BURST_MAX = 4,
  parameter logic [31:0] TIMER_ADDR     = 32'h80006000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_INSTR  = 2'd1,
    OWN_DMEM   = 2'd2,
    OWN_DTIMER = 2'd3
  } owner_e;

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic        d_timer;
  logic        d_read;

  assign d_timer = (d_address == TIMER_ADDR);
  assign d_read  = (d_we == 4'b0000);

  // Fetch only overrides a pending data request once the data burst has hit its bound.
  assign i_gnt = i_req && (!d_req || (starve_cnt_q == BURST_MAX));
  assign d_gnt = d_req && !i_gnt;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;
    if (i_gnt) begin
      mem_en      = 1'b1;
      mem_address = i_address;
    end else if (d_gnt) begin
      mem_en      = !d_timer;
      mem_we      = d_we;
      mem_address = d_address;
      mem_wdata   = d_wdata;
    end
  end

  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    timer_d      = timer_q;
    cycle_cnt_d  = cycle_cnt_q + 32'd1;

    if (i_gnt) begin
      owner_d = OWN_INSTR;
    end else if (d_gnt && d_read) begin
      owner_d = d_timer ? OWN_DTIMER : OWN_DMEM;
    end

    // The captured value is the count at the grant edge, not at the response cycle.
    if (d_gnt && d_read && d_timer) begin
      timer_d = cycle_cnt_q;
    end

    if (!i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q != BURST_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
      cycle_cnt_q  <= 32'h0;
      timer_q      <= 32'h0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign i_rvalid = (owner_q == OWN_INSTR);
  assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
  assign d_rvalid = (owner_q == OWN_DMEM) || (owner_q == OWN_DTIMER);

  always_comb begin
    d_rdata = 32'h0;
    if (owner_q == OWN_DMEM) begin
      d_rdata = mem_rdata;
    end else if (owner_q == OWN_DTIMER) begin
      d_rdata = timer_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for steady-state arbitration and
// hand-written sequences for reset, timer capture and reset during an outstanding read.
module tb_mem_port_arbiter;

  localparam logic [31:0] TADDR = 32'h80006000;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_address;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_address, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_address, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.DATA_BURST_MAX(4), .TIMER_ADDR(TADDR)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_address(d_address), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, read-first, one cycle read latency.
  logic [31:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      int w;
      logic [31:0] old;
      w = int'(mem_address[31:2]);
      old = ram.exists(w) ? ram[w] : 32'h0;
      mem_rdata <= old;
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) old[b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
      ram[w] = old;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    i_req = ir; i_address = ia; d_req = dr; d_we = dw; d_address = da; d_wdata = dd;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        igt, dgt, men;
    logic [3:0]  mwe;
    logic [31:0] maddr;
    logic        irv;
    logic [31:0] ird;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [3:0] dw,
                              logic [31:0] da, logic [31:0] dd, logic ig, logic dg,
                              logic me, logic [3:0] mw, logic [31:0] ma, logic irv,
                              logic [31:0] ird, logic drv, logic [31:0] drd);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dd;
    v.igt = ig; v.dgt = dg; v.men = me; v.mwe = mw; v.maddr = ma;
    v.irv = irv; v.ird = ird; v.drv = drv; v.drd = drd;
    return v;
  endfunction

  vec_t vecs [20];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram[32'h100 >> 2] = 32'hA;
    ram[32'h104 >> 2] = 32'hB;
    ram[32'h108 >> 2] = 32'hC;
    ram[32'h300 >> 2] = 32'h33;
    ram[32'h400 >> 2] = 32'h44;

    // Row fields: inputs | igt dgt men mwe maddr | irv ird drv drd (response of previous row)
    vecs[0]  = mk(1, 32'h100, 0, 4'h0, 32'h0,   32'h0, 1, 0, 1, 4'h0, 32'h100, 0, 32'h0,  0, 32'h0);
    vecs[1]  = mk(1, 32'h104, 0, 4'h0, 32'h0,   32'h0, 1, 0, 1, 4'h0, 32'h104, 1, 32'hA,  0, 32'h0);
    vecs[2]  = mk(1, 32'h108, 0, 4'h0, 32'h0,   32'h0, 1, 0, 1, 4'h0, 32'h108, 1, 32'hB,  0, 32'h0);
    vecs[3]  = mk(0, 32'h0,   0, 4'h0, 32'h0,   32'h0, 0, 0, 0, 4'h0, 32'h0,   1, 32'hC,  0, 32'h0);
    vecs[4]  = mk(0, 32'h0,   0, 4'h0, 32'h0,   32'h0, 0, 0, 0, 4'h0, 32'h0,   0, 32'h0,  0, 32'h0);
    vecs[5]  = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  0, 32'h0);
    vecs[6]  = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[7]  = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[8]  = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[9]  = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 1, 0, 1, 4'h0, 32'h400, 0, 32'h0,  1, 32'h33);
    vecs[10] = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 1, 32'h44, 0, 32'h0);
    vecs[11] = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[12] = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[13] = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 0, 1, 1, 4'h0, 32'h300, 0, 32'h0,  1, 32'h33);
    vecs[14] = mk(1, 32'h400, 1, 4'h0, 32'h300, 32'h0, 1, 0, 1, 4'h0, 32'h400, 0, 32'h0,  1, 32'h33);
    vecs[15] = mk(0, 32'h0,   0, 4'h0, 32'h0,   32'h0, 0, 0, 0, 4'h0, 32'h0,   1, 32'h44, 0, 32'h0);
    vecs[16] = mk(0, 32'h0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 1, 1, 4'h3, 32'h200, 0, 32'h0, 0, 32'h0);
    vecs[17] = mk(0, 32'h0, 1, 4'h0, 32'h200, 32'h0, 0, 1, 1, 4'h0, 32'h200, 0, 32'h0, 0, 32'h0);
    vecs[18] = mk(0, 32'h0, 0, 4'h0, 32'h0,   32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 1, 32'h0000BEEF);
    vecs[19] = mk(0, 32'h0, 0, 4'h0, 32'h0,   32'h0, 0, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Reset held with both requesters active: no responses may appear.
    reset = 1'b0;
    drive(1, 32'h100, 1, 4'h0, 32'h300, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_d_gnt", d_gnt, 1);
    end
    // First edge after release samples cycle_cnt = 0.
    reset = 1'b1;
    drive(0, 32'h0, 1, 4'h0, TADDR, 32'h0);
    @(negedge clk);
    chk("first_timer_rvalid", d_rvalid, 1);
    chk("first_timer_rdata", d_rdata, 0);
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].ireq, vecs[k].iaddr, vecs[k].dreq, vecs[k].dwe, vecs[k].daddr, vecs[k].dwdata);
      #1;
      chk($sformatf("v%0d_i_gnt", k), i_gnt, vecs[k].igt);
      chk($sformatf("v%0d_d_gnt", k), d_gnt, vecs[k].dgt);
      chk($sformatf("v%0d_mem_en", k), mem_en, vecs[k].men);
      chk($sformatf("v%0d_mem_we", k), mem_we, vecs[k].mwe);
      chk($sformatf("v%0d_mem_address", k), mem_address, vecs[k].maddr);
      chk($sformatf("v%0d_i_rvalid", k), i_rvalid, vecs[k].irv);
      chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].ird);
      chk($sformatf("v%0d_d_rvalid", k), d_rvalid, vecs[k].drv);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].drd);
      @(negedge clk);
    end

    // Timer: read at cycle 10, drop a write, then read again at cycle 12.
    reset = 1'b0;
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    drive(0, 32'h0, 1, 4'h0, TADDR, 32'h0);
    #1;
    chk("timer_rd_gnt", d_gnt, 1);
    chk("timer_rd_mem_en", mem_en, 0);
    @(negedge clk);
    chk("timer_rd_rvalid", d_rvalid, 1);
    chk("timer_rd_rdata", d_rdata, 10);
    drive(0, 32'h0, 1, 4'hF, TADDR, 32'h12345678);
    #1;
    chk("timer_wr_gnt", d_gnt, 1);
    chk("timer_wr_mem_en", mem_en, 0);
    @(negedge clk);
    chk("timer_wr_rvalid", d_rvalid, 0);
    chk("timer_wr_rdata", d_rdata, 0);
    drive(0, 32'h0, 1, 4'h0, TADDR, 32'h0);
    @(negedge clk);
    chk("timer_rd2_rdata", d_rdata, 12);
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);

    // Reset asserted while a data read response is outstanding.
    drive(0, 32'h0, 1, 4'h0, 32'h300, 32'h0);
    @(negedge clk);
    chk("midrst_pre_rvalid", d_rvalid, 1);
    chk("midrst_pre_rdata", d_rdata, 32'h33);
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk("midrst_rvalid_drop", d_rvalid, 0);
    chk("midrst_rdata_drop", d_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_post_d_rvalid", d_rvalid, 0);
    chk("midrst_post_i_rvalid", i_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
